signed_minmax_scanner: RTL

Frame-based scanner for signed samples. It accepts a stream of COUNT two's-complement samples over a valid/ready handshake and reports the frame's maximum and minimum values with their sample indices. A single signed magnitude comparator, the same GT/LT/EQ function used elsewhere in the design, is time-shared between the max check and the min check under an FSM. The block sits between a sample source and any consumer that needs per-frame extrema.

---
 rtl/signed_minmax_scanner.sv | 131 +++++++++++++
 1 files changed

// File: rtl/signed_minmax_scanner.sv
// signed_minmax_scanner: per-frame signed max/min search with sample indices,
// sharing one signed comparator between the max and min checks.
module signed_cmp #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             gt,
    output logic             lt,
    output logic             eq
);
    assign gt = $signed(a) > $signed(b);
    assign lt = $signed(a) < $signed(b);
    assign eq = a == b;
endmodule

module signed_minmax_scanner #(
    parameter int  WIDTH = 4,
    parameter int  COUNT = 8,
    localparam int IW    = (COUNT > 1) ? $clog2(COUNT) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] max_out,
    output logic [WIDTH-1:0] min_out,
    output logic [IW-1:0]    max_idx,
    output logic [IW-1:0]    min_idx
);
    localparam int             CW      = $clog2(COUNT + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(COUNT);

    typedef enum logic [2:0] {IDLE, FIRST, ACCEPT, CMP_MAX, CMP_MIN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [IW-1:0]    hidx_q, hidx_d;
    logic [WIDTH-1:0] max_q, max_d, min_q, min_d;
    logic [IW-1:0]    maxi_q, maxi_d, mini_q, mini_d;
    logic             gt, lt, eq;

    // Operand B follows the state: running max in CMP_MAX, running min otherwise.
    signed_cmp #(.WIDTH(WIDTH)) u_cmp (
        .a  (hold_q),
        .b  (state_q == CMP_MAX ? max_q : min_q),
        .gt (gt),
        .lt (lt),
        .eq (eq)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        hidx_d  = hidx_q;
        max_d   = max_q;
        min_d   = min_q;
        maxi_d  = maxi_q;
        mini_d  = mini_q;
        case (state_q)
            IDLE: state_d = start ? FIRST : IDLE;
            FIRST: if (in_valid) begin
                max_d   = in_data;
                min_d   = in_data;
                maxi_d  = '0;
                mini_d  = '0;
                cnt_d   = CW'(1);
                state_d = (COUNT == 1) ? DONE : ACCEPT;
            end
            ACCEPT: if (in_valid) begin
                hold_d  = in_data;
                hidx_d  = cnt_q[IW-1:0];
                cnt_d   = cnt_q + CW'(1);
                state_d = CMP_MAX;
            end
            CMP_MAX: begin
                // Strict compare only: ties keep the earliest index.
                if (gt && !eq) begin
                    max_d  = hold_q;
                    maxi_d = hidx_q;
                end
                state_d = CMP_MIN;
            end
            CMP_MIN: begin
                if (lt && !eq) begin
                    min_d  = hold_q;
                    mini_d = hidx_q;
                end
                state_d = (cnt_q == CNT_MAX) ? DONE : ACCEPT;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
            hidx_q  <= '0;
            max_q   <= '0;
            min_q   <= '0;
            maxi_q  <= '0;
            mini_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            hidx_q  <= hidx_d;
            max_q   <= max_d;
            min_q   <= min_d;
            maxi_q  <= maxi_d;
            mini_q  <= mini_d;
        end
    end

    assign in_ready = (state_q == FIRST) || (state_q == ACCEPT);
    assign busy     = state_q != IDLE;
    assign done     = state_q == DONE;
    assign max_out  = max_q;
    assign min_out  = min_q;
    assign max_idx  = maxi_q;
    assign min_idx  = mini_q;
endmodule
